muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It sits beside the ALU in EX and takes the decoded R-type opcode/funct plus both source operands. It sequences a 32-step shift-add multiplier or restoring divider and stalls the pipeline while an operation is in flight. It also serves mfhi/mflo/mthi/mtlo.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider with HI/LO registers.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply (divide unchanged).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                           F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU = 6'b011011;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic                 done_q, done_d;

    logic                 is_r, f_mul, f_div, f_signed, f_mfhi, f_mflo, f_mthi, f_mtlo;
    logic                 md_op, hl_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, div_diff;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;

    assign is_r     = (opcode == 6'b000000);
    assign f_mul    = is_r & ((funct == F_MULT) | (funct == F_MULTU));
    assign f_div    = is_r & ((funct == F_DIV)  | (funct == F_DIVU));
    assign f_signed = (funct == F_MULT) | (funct == F_DIV);
    assign f_mfhi   = is_r & (funct == F_MFHI);
    assign f_mflo   = is_r & (funct == F_MFLO);
    assign f_mthi   = is_r & (funct == F_MTHI);
    assign f_mtlo   = is_r & (funct == F_MTLO);

    assign md_op = ex_valid & ~flush & (f_mul | f_div);
    assign hl_op = ex_valid & ~flush & (f_mfhi | f_mflo | f_mthi | f_mtlo);

    assign busy  = (state_q == CALC) | (state_q == FIX);
    assign stall = busy & (md_op | hl_op);
    assign done  = done_q;

    assign hilo_rdata = (hl_op & f_mfhi) ? hi_q :
                        (hl_op & f_mflo) ? lo_q : '0;

    assign a_neg = f_signed & srca[WIDTH-1];
    assign b_neg = f_signed & srcb[WIDTH-1];
    assign a_mag = a_neg ? -srca : srca;
    assign b_mag = b_neg ? -srcb : srcb;

    // Multiply: acc = {partial product high, multiplier shifting out at bit 0}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opd_q;
    assign prod_fix  = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_op) begin
                    is_div_d  = f_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    count_d   = '0;
                    if (f_div) begin
                        if (srcb == '0) begin
                            acc_d     = {srca, {WIDTH{1'b1}}};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = FIX;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opd_d   = b_mag;
                            state_d = CALC;
                        end
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        state_d = FIX;
`else
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opd_d   = a_mag;
                        state_d = CALC;
`endif
                    end
                end else if (hl_op) begin
                    if (f_mthi) hi_d = srca;
                    if (f_mtlo) lo_d = srca;
                end
            end
            CALC: begin
                count_d = count_q + CW'(1);
                if (is_div_q)
                    acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                                   : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                else
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                if (count_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything: abort, keep HI/LO, suppress done.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MULT_EN).
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                           F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU = 6'b011011;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_CYC = 1;
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_CYC = 33;
    localparam int MUL_STALL = 32;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        busy;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic        done;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .opcode(opcode),
        .funct(funct), .srca(srca), .srcb(srcb), .flush(flush), .busy(busy),
        .stall(stall), .hilo_rdata(hilo_rdata), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        opcode   = 6'b000000;
        funct    = f;
        srca     = a;
        srcb     = b;
    endtask

    task automatic idle;
        ex_valid = 1'b0;
        funct    = 6'b000000;
        srca     = '0;
        srcb     = '0;
    endtask

    // Issue an md op, then count cycles until done and how many of those had busy=1.
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int bcnt);
        drive(f, a, b);
        tick;
        idle;
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            tick;
            cyc++;
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(F_MFHI, '0, '0);
        #1;
        check({tag, " hi"}, hilo_rdata, hi);
        drive(F_MFLO, '0, '0);
        #1;
        check({tag, " lo"}, hilo_rdata, lo);
        idle;
    endtask

    initial begin
        int cyc, bcnt, n;
        reset_n = 1'b0;
        flush   = 1'b0;
        idle;
        opcode  = '0;
        repeat (2) @(posedge clk);
        #3;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        reset_n = 1'b1;
        tick;
        check_hilo("reset", 32'h0, 32'h0);

        // mthi / mtlo in IDLE, no stall
        drive(F_MTHI, 32'h1234, '0);
        #1 check("mthi stall", {31'b0, stall}, 32'd0);
        tick;
        drive(F_MTLO, 32'h5678, '0);
        #1 check("mtlo stall", {31'b0, stall}, 32'd0);
        tick;
        idle;
        check_hilo("mt", 32'h1234, 32'h5678);

        // signed mult -1 * 2
        run_md(F_MULT, 32'hFFFFFFFF, 32'd2, cyc, bcnt);
        check("mult done cycle", cyc, MUL_CYC);
        check("mult busy cycles", bcnt, MUL_CYC);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
        tick;
        check("done one pulse", {31'b0, done}, 32'd0);

        run_md(F_MULTU, 32'hFFFFFFFF, 32'd2, cyc, bcnt);
        check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        run_md(F_DIV, 32'hFFFFFFF9, 32'd2, cyc, bcnt);
        check("div busy cycles", bcnt, 33);
        check_hilo("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_md(F_DIVU, 32'd100, 32'd7, cyc, bcnt);
        check_hilo("divu 100/7", 32'd2, 32'd14);

        run_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, bcnt);
        check_hilo("div min/-1", 32'h0, 32'h80000000);

        run_md(F_DIV, 32'd5, 32'd0, cyc, bcnt);
        check("div0 busy cycles", bcnt, 1);
        check("div0 done cycle", cyc, 1);
        check_hilo("div0", 32'd5, 32'hFFFFFFFF);

        // multiply followed by a dependent mflo held by stall
        drive(F_MULT, 32'd3, 32'd4);
        tick;
        idle;
        tick;
        drive(F_MFLO, '0, '0);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick;
        end
        check("mflo stall cycles", n, MUL_STALL);
        check("mflo after stall", hilo_rdata, 32'd12);
        check("done with mflo", {31'b0, done}, 32'd1);
        idle;
        tick;

        // flush an in-flight divide
        drive(F_MTHI, 32'hAAAA, '0);
        tick;
        drive(F_MTLO, 32'hBBBB, '0);
        tick;
        drive(F_DIVU, 32'd100, 32'd7);
        tick;
        idle;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        n = 0;
        repeat (40) begin
            if (done) n++;
            tick;
        end
        check("flush no done", n, 0);
        check_hilo("flush keep", 32'hAAAA, 32'hBBBB);

        // asynchronous reset in the middle of a multiply
        drive(F_MULT, 32'd7, 32'd9);
        tick;
        idle;
        repeat (19) tick;
        drive(F_MFHI, '0, '0);
        #2 reset_n = 1'b0;
        #1;
        check("arst busy", {31'b0, busy}, 32'd0);
        check("arst stall", {31'b0, stall}, 32'd0);
        check("arst hi", hilo_rdata, 32'd0);
        drive(F_MFLO, '0, '0);
        #1 check("arst lo", hilo_rdata, 32'd0);
        idle;
        reset_n = 1'b1;
        tick;
        check("post reset done", {31'b0, done}, 32'd0);

`ifdef MULDIV_FAST_MULT_EN
        run_md(F_MULT, 32'd3, 32'd4, cyc, bcnt);
        check("fast mult cycles", cyc, 1);
        check_hilo("fast mult", 32'd0, 32'd12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
